// File: rtl/player_action_encoder_pkg.sv
// Shared definitions for the 6-bit one-hot player action bus.
// Both the encoder and the player modules import this package, so the bit
// layout and the priority order have a single definition.
package player_action_encoder_pkg;

  localparam int NUM_BTN = 6;

  typedef logic [NUM_BTN-1:0] action_t;

  // Bit positions on the action bus and on the raw button vector.
  localparam int BIT_PUNCH = 0;
  localparam int BIT_KICK  = 1;
  localparam int BIT_JUMP  = 2;
  localparam int BIT_WAIT  = 3;
  localparam int BIT_LEFT  = 4;
  localparam int BIT_RIGHT = 5;

  // One-hot action encodings.
  localparam action_t NO_ACTION  = 6'b000000;
  localparam action_t PUNCH      = 6'b000001;
  localparam action_t KICK       = 6'b000010;
  localparam action_t JUMP       = 6'b000100;
  localparam action_t WAIT       = 6'b001000;
  localparam action_t MOVE_LEFT  = 6'b010000;
  localparam action_t MOVE_RIGHT = 6'b100000;

  // Buttons that generate edge-triggered press events (WAIT is a level).
  localparam action_t PRESS_MASK = PUNCH | KICK | JUMP | MOVE_LEFT | MOVE_RIGHT;

  // Arbitration rank, lowest first: MOVE_LEFT < MOVE_RIGHT < JUMP < KICK < PUNCH.
  typedef enum logic [2:0] {
    PRIO_NONE  = 3'd0,
    PRIO_LEFT  = 3'd1,
    PRIO_RIGHT = 3'd2,
    PRIO_JUMP  = 3'd3,
    PRIO_KICK  = 3'd4,
    PRIO_PUNCH = 3'd5
  } action_prio_e;

  localparam int NUM_PRIO = 5;
  localparam int PRIO_ORDER [NUM_PRIO] = '{BIT_LEFT, BIT_RIGHT, BIT_JUMP, BIT_KICK, BIT_PUNCH};

  // Rank of the highest-priority action present in a (possibly multi-hot) vector.
  function automatic action_prio_e action_prio(input action_t a);
    action_prio_e p;
    p = PRIO_NONE;
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (a[PRIO_ORDER[i]]) p = action_prio_e'(3'(i + 1));
    end
    return p;
  endfunction

  // Keep only the highest-priority request of a multi-hot vector.
  function automatic action_t highest_action(input action_t req);
    action_t r;
    r = NO_ACTION;
    for (int i = 0; i < NUM_PRIO; i++) begin
      if (req[PRIO_ORDER[i]]) r = action_t'(1) << PRIO_ORDER[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/player_action_encoder_button_debouncer.sv
// One push-button lane: 2-flop synchroniser, stability counter and debounced
// level, plus a one-cycle pulse on each debounced rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             level_reg;
  logic             rise_reg;

  // Synchronise, then flip the level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= 2'b00;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn_raw};
      rise_reg <= 1'b0;
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_reg   <= '0;
        level_reg <= ~level_reg;
        rise_reg  <= ~level_reg;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/player_action_encoder.sv
// Player action encoder: debounced buttons -> press arbitration into a single
// pending action -> one one-hot action strobe per game tick, with attack
// cooldown and optional left/right mirroring for the right-side player.
module player_action_encoder
  import player_action_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ATTACK_COOLDOWN = 2,
  parameter bit MIRROR          = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                game_tick,
  input  logic [NUM_BTN-1:0]  btn,
  output logic [NUM_BTN-1:0]  action_out,
  output logic                action_valid,
  output logic                dropped
);

  localparam int CD_W = (ATTACK_COOLDOWN > 0) ? $clog2(ATTACK_COOLDOWN + 1) : 1;

  action_t          level_vec;
  action_t          rise_vec;

  action_t          pending_reg;
  action_t          action_out_reg;
  logic             action_valid_reg;
  logic             dropped_reg;
  logic [CD_W-1:0]  cd_reg;

  action_t          press_ev;
  action_t          arb_ev;
  action_t          cand;
  action_t          base;
  action_t          pending_next;
  action_t          out_next;
  logic [CD_W-1:0]  cd_next;
  logic             wait_held;
  logic             emit_attack;
  logic             attack_blocked;
  logic             attack_hit;
  logic             rl_cancel;
  logic             multi_hit;
  logic             accept;
  logic             dropped_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debouncer (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn[gi]),
        .level  (level_vec[gi]),
        .rise   (rise_vec[gi])
      );
    end
  endgenerate

  // Tick emission, cooldown update, then arbitration of this cycle's press events.
  always_comb begin
    // Only the WAIT button is level-sensitive; the rest act on press edges.
    wait_held = |(level_vec & WAIT);

    // Emission: pending wins, otherwise a held WAIT, otherwise nothing.
    out_next = NO_ACTION;
    if (game_tick) begin
      if (pending_reg != NO_ACTION) out_next = pending_reg;
      else if (wait_held)           out_next = WAIT;
    end

    // Cooldown reloads on an emitted attack, otherwise counts ticks down to 0.
    emit_attack = game_tick & (pending_reg[BIT_PUNCH] | pending_reg[BIT_KICK]);
    cd_next     = cd_reg;
    if (game_tick) begin
      if (emit_attack)        cd_next = CD_W'(ATTACK_COOLDOWN);
      else if (cd_reg != '0)  cd_next = cd_reg - CD_W'(1);
    end

    // Press events; the right-side player swaps the two move directions.
    press_ev = rise_vec & PRESS_MASK;
    if (MIRROR) begin
      press_ev[BIT_RIGHT] = rise_vec[BIT_LEFT];
      press_ev[BIT_LEFT]  = rise_vec[BIT_RIGHT];
    end

    // Events in a tick cycle see the cooldown as it stands after the emission.
    attack_blocked = (cd_next != '0);
    attack_hit     = attack_blocked & (press_ev[BIT_PUNCH] | press_ev[BIT_KICK]);
    arb_ev         = press_ev;
    if (attack_blocked) begin
      arb_ev[BIT_PUNCH] = 1'b0;
      arb_ev[BIT_KICK]  = 1'b0;
    end

    // Opposite moves together with nothing stronger cancel each other out.
    rl_cancel = arb_ev[BIT_RIGHT] & arb_ev[BIT_LEFT] &
                ~(arb_ev[BIT_JUMP] | arb_ev[BIT_KICK] | arb_ev[BIT_PUNCH]);
    if (rl_cancel) begin
      arb_ev[BIT_RIGHT] = 1'b0;
      arb_ev[BIT_LEFT]  = 1'b0;
    end

    cand      = highest_action(arb_ev);
    multi_hit = (arb_ev != cand);

    // A tick clears pending before the new event is considered.
    base   = game_tick ? NO_ACTION : pending_reg;
    accept = (cand != NO_ACTION) && (action_prio(cand) > action_prio(base));
    pending_next = accept ? cand : base;

    dropped_next = attack_hit | rl_cancel | multi_hit |
                   ((cand != NO_ACTION) & ~accept) |
                   (accept & (base != NO_ACTION));
  end

  // Register pending action, cooldown and the single-cycle output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg      <= NO_ACTION;
      cd_reg           <= '0;
      action_out_reg   <= NO_ACTION;
      action_valid_reg <= 1'b0;
      dropped_reg      <= 1'b0;
    end else begin
      pending_reg      <= pending_next;
      cd_reg           <= cd_next;
      action_out_reg   <= out_next;
      action_valid_reg <= (out_next != NO_ACTION);
      dropped_reg      <= dropped_next;
    end
  end

  assign action_out   = action_out_reg;
  assign action_valid = action_valid_reg;
  assign dropped      = dropped_reg;

endmodule

// File: doc/player_action_encoder.md
Name: player_action_encoder

Overview:
- Producer side of the 6-bit one-hot player action bus consumed by the left/right player modules.
- Turns raw asynchronous push-button levels into at most one clean one-hot action per game tick.
- Per button: synchronises and debounces; press arbitration, WAIT generation, attack cooldown and left/right mirroring.
- One instance per player; action_out drives that player's own input and the opponent's input.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required to change a debounced level (min 1).
- ATTACK_COOLDOWN, 2, game ticks after an emitted PUNCH/KICK during which new attacks are discarded (0 = none).
- MIRROR, 0, 1 swaps the MOVE_RIGHT/MOVE_LEFT button mapping (right-side player facing).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- game_tick  input  1  one-cycle strobe; one game step per strobe
- btn  input  6  raw buttons, action bit order [5]=right [4]=left [3]=wait [2]=jump [1]=kick [0]=punch
- action_out  output  6  one-hot action; MOVE_RIGHT=100000 MOVE_LEFT=010000 WAIT=001000 JUMP=000100 KICK=000010 PUNCH=000001; 000000 = none
- action_valid  output  1  high in the same cycle action_out is non-zero
- dropped  output  1  one-cycle pulse when a debounced press is discarded

Behaviour:
- Reset is asynchronous and active-high; it is honoured mid-operation.
  - Reset values: action_out=0, action_valid=0, dropped=0, pending=0, cooldown=0.
  - Synchroniser flops and debounced levels reset to 0; debounce counters reset to 0.
- Synchronisation: a 2-flop synchroniser per button bit.
- Debounce: a per-bit counter.
  - It increments while the synchronised value differs from the debounced level.
  - It clears whenever they match.
  - The debounced level flips when the counter reaches DEBOUNCE_CYCLES.
  - Any glitch shorter than DEBOUNCE_CYCLES never propagates.
- Press events: a debounced rising edge on right, left, jump, kick or punch produces a one-cycle press event.
  - WAIT is level-sensitive; it has no press event.
- MIRROR=1: the right and left press events are swapped before arbitration.
- Pending register: holds one one-hot action. Priority, high to low: PUNCH > KICK > JUMP > MOVE_RIGHT > MOVE_LEFT.
  - A new event replaces pending only if it has strictly higher priority; otherwise the new event is dropped (dropped=1).
  - A replaced pending action also pulses dropped (one pulse per cycle maximum).
  - Simultaneous events in one cycle: the highest priority wins; right+left with no higher action cancels both moves and pulses dropped.
- Attack cooldown: while cooldown>0, PUNCH/KICK events are dropped and never enter pending.
- game_tick cycle T:
  - Pending non-zero: register action_out=pending at T+1 and clear pending.
  - Pending zero and debounced wait=1: emit WAIT at T+1.
  - Otherwise emit 000000.
  - Emitting PUNCH/KICK loads cooldown=ATTACK_COOLDOWN; otherwise cooldown decrements (saturating at 0) on each tick.
  - A press event arriving in the tick cycle T is processed after the emission: it lands in a freshly cleared pending and waits for the next tick.
- action_out/action_valid: non-zero for exactly the one cycle T+1, zero in all other cycles. This makes each action a single-cycle strobe to the player modules.
  - Held WAIT across consecutive ticks yields one WAIT strobe per tick.
- Latency: raw press to pending ≤ 2 + DEBOUNCE_CYCLES + 1 cycles. Tick to action_out is 1 cycle.
- game_tick held high for multiple cycles: each high cycle is treated as a tick (no edge detection); ticks must be single-cycle.

Decomposition:
- Shared package/header holds:
  - the action one-hot constants (MOVE_RIGHT … PUNCH, NO_ACTION) and bit-index names;
  - the priority order, so that player modules and this encoder share a single definition.
- Natural sub-module: button_debouncer. It contains the synchroniser, counter and debounced level for one bit, parameterised by DEBOUNCE_CYCLES, and is instantiated six times.

Test Plan:
- Reset and glitch: rst=1 then 0; btn[0] pulsed for 3 cycles with DEBOUNCE_CYCLES=4, then tick → action_out=000000, dropped never asserted.
- Press then tick: btn[0] held for 10 cycles, game_tick at cycle 20 → action_out=000001 and action_valid=1 at cycle 21 only, 000000 at cycle 22.
- Priority: jump press then kick press before the tick → dropped pulse on the kick arrival, tick emits 000010; kick then jump → jump dropped, tick emits 000010.
- Cooldown: punch emitted at tick 1; punch pressed again before ticks 2 and 3 → both dropped, ticks 2 and 3 emit 000000; a punch pressed after tick 3 is emitted at tick 4.
- WAIT and mirror: btn[3] held across 3 ticks → 001000 strobe after each tick; MIRROR=1 with btn[5] press → tick emits 010000.
- Async reset mid-operation: pending=000100 and rst pulsed for 1 cycle without a clock edge → all outputs 0 immediately; the next tick emits 000000.
